// File: rtl/weight_row_packer_pkg.sv
// Shared constants and FSM state encoding for the weight row packer.
package weight_row_packer_pkg;

    localparam int unsigned WEIGHT_WIDTH     = 16;
    localparam int unsigned WEIGHT_PIXEL_NUM = 32;
    localparam int unsigned ADDR_WIDTH       = 6;
    localparam int unsigned ROW_WIDTH        = WEIGHT_WIDTH * WEIGHT_PIXEL_NUM;
    localparam int unsigned LANE_WIDTH       = $clog2(WEIGHT_PIXEL_NUM);
    localparam int unsigned ROW_IDX_WIDTH    = $clog2(ROW_WIDTH);
    localparam int unsigned ROWS_WIDTH       = ADDR_WIDTH + 1;
    localparam int unsigned MAX_ROWS         = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/weight_row_packer.sv
// Packs a stream of 16-bit weights into 512-bit rows and writes each row to
// the weight SRAM at consecutive addresses from a programmed base.
// Optional macro WPACK_FLUSH_EN: a partial final row is zero-padded and
// written; otherwise it is dropped without an SRAM write.
module weight_row_packer
    import weight_row_packer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WEIGHT_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    sram_csb,
    output logic                    sram_wsb,
    output logic [ADDR_WIDTH-1:0]   sram_waddr,
    output logic [ROW_WIDTH-1:0]    sram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [ROWS_WIDTH-1:0]   rows_written,
    output logic                    wrap_err
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(WEIGHT_PIXEL_NUM - 1);
    localparam int unsigned           LANE_SHIFT = $clog2(WEIGHT_WIDTH);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [LANE_WIDTH-1:0]    lane_q, lane_d;
    logic [ROW_WIDTH-1:0]     row_buf_q, row_buf_d;
    logic                     last_seen_q, last_seen_d;
    logic [ROWS_WIDTH-1:0]    rows_d;
    logic                     wrap_d;
    logic [ADDR_WIDTH-1:0]    waddr_d;
    logic [ROW_WIDTH-1:0]     wdata_d;
    logic                     hs;
    logic [LANE_WIDTH-1:0]    lane_rev;
    logic [ROW_IDX_WIDTH-1:0] lane_lsb;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        row_buf_d   = row_buf_q;
        last_seen_d = last_seen_q;
        rows_d      = rows_written;
        wrap_d      = wrap_err;
        waddr_d     = sram_waddr;
        wdata_d     = sram_wdata;
        hs          = in_valid && in_ready;
        lane_rev    = LAST_LANE - lane_q;
        lane_lsb    = ROW_IDX_WIDTH'(lane_rev) << LANE_SHIFT;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    addr_d      = start_addr;
                    lane_d      = '0;
                    row_buf_d   = '0;
                    rows_d      = '0;
                    wrap_d      = 1'b0;
                    last_seen_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (hs) begin
                    row_buf_d[lane_lsb +: WEIGHT_WIDTH] = in_data;
                    lane_d = lane_q + LANE_WIDTH'(1);
                    if (lane_q == LAST_LANE) begin
                        state_d     = ST_WRITE;
                        last_seen_d = in_last;
                    end else if (in_last) begin
`ifdef WPACK_FLUSH_EN
                        state_d     = ST_WRITE;
                        last_seen_d = 1'b1;
`else
                        state_d     = ST_DONE;
                        lane_d      = '0;
                        row_buf_d   = '0;
`endif
                    end
                end
            end
            ST_WRITE: begin
                addr_d    = addr_q + ADDR_WIDTH'(1);
                lane_d    = '0;
                row_buf_d = '0;
                if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                    wrap_d = 1'b1;
                end
                if (rows_written < ROWS_WIDTH'(MAX_ROWS)) begin
                    rows_d = rows_written + ROWS_WIDTH'(1);
                end
                state_d = last_seen_q ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Latch the completed row and its address as the write cycle begins.
        if (state_d == ST_WRITE) begin
            waddr_d = addr_q;
            wdata_d = row_buf_d;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            lane_q       <= '0;
            row_buf_q    <= '0;
            last_seen_q  <= 1'b0;
            in_ready     <= 1'b0;
            sram_csb     <= 1'b1;
            sram_wsb     <= 1'b1;
            sram_waddr   <= '0;
            sram_wdata   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rows_written <= '0;
            wrap_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            row_buf_q    <= row_buf_d;
            last_seen_q  <= last_seen_d;
            in_ready     <= (state_d == ST_FILL);
            sram_csb     <= (state_d != ST_WRITE);
            sram_wsb     <= (state_d != ST_WRITE);
            sram_waddr   <= waddr_d;
            sram_wdata   <= wdata_d;
            busy         <= (state_d != ST_IDLE);
            done         <= (state_d == ST_DONE);
            rows_written <= rows_d;
            wrap_err     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_weight_row_packer.sv
// Directed self-checking bench for weight_row_packer.
module tb_weight_row_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   start_addr = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         sram_csb;
    logic         sram_wsb;
    logic [5:0]   sram_waddr;
    logic [511:0] sram_wdata;
    logic         busy;
    logic         done;
    logic [6:0]   rows_written;
    logic         wrap_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;
    int start_cyc = 0;
    logic [5:0]   wr_addr_q[$];
    logic [511:0] wr_data_q[$];

    weight_row_packer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .sram_csb(sram_csb), .sram_wsb(sram_wsb), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .busy(busy), .done(done),
        .rows_written(rows_written), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_csb && !sram_wsb) begin
                wr_addr_q.push_back(sram_waddr);
                wr_data_q.push_back(sram_wdata);
                last_wr_cyc = cyc;
            end
            if (busy && !in_ready && !done) stall_cnt++;
            if (done) done_cnt++;
        end
    end

    // Expected row: n weights base, base+1, ... first in the top lane, rest zero.
    function automatic logic [511:0] row_of(input logic [15:0] base, input int n);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            r = r << 16;
            if (k < n) r[15:0] = base + 16'(k);
        end
        return r;
    endfunction

    task automatic do_start(input logic [5:0] a);
        start_addr = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Sends n weights base+i; optional random gaps; optional start pulse at weight restart_at.
    task automatic send(input int n, input logic [15:0] base, input bit last,
                        input bit gaps, input int restart_at);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (i == restart_at) begin
                start = 1'b1;
                start_addr = 6'd40;
            end
            in_valid = 1'b1;
            in_data = base + 16'(i);
            in_last = last && (i == n - 1);
            begin
                bit acc;
                int w;
                acc = 1'b0;
                w = 0;
                while (!acc) begin
                    acc = in_ready;
                    @(posedge clk); #1;
                    start = 1'b0;
                    w++;
                    if (!acc && w > 200) begin
                        checks++; failures++;
                        $display("FAIL handshake_timeout: weight %0d not accepted after %0d cycles", i, w);
                        in_valid = 1'b0;
                        in_last = 1'b0;
                        return;
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_at);
        int w;
        w = 0;
        while (!done && w < budget) begin
            @(posedge clk); #1;
            w++;
        end
        done_at = cyc;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, w);
        end
    endtask

    task automatic test_reset();
        int b;
        repeat (2) @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++; if (sram_csb !== 1'b1) begin failures++; $display("FAIL rst_csb: got %b required 1", sram_csb); end
        checks++; if (sram_wsb !== 1'b1) begin failures++; $display("FAIL rst_wsb: got %b required 1", sram_wsb); end
        checks++; if (sram_waddr !== 6'd0) begin failures++; $display("FAIL rst_waddr: got %0h required 0", sram_waddr); end
        checks++; if (sram_wdata !== 512'd0) begin failures++; $display("FAIL rst_wdata: got %0h required 0", sram_wdata); end
        checks++; if ({busy, done, wrap_err} !== 3'b000) begin failures++; $display("FAIL rst_flags: busy/done/wrap got %b required 000", {busy, done, wrap_err}); end
        checks++; if (rows_written !== 7'd0) begin failures++; $display("FAIL rst_rows: got %0d required 0", rows_written); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset in the middle of a row.
        b = wr_addr_q.size();
        do_start(6'd3);
        send(10, 16'h0100, 1'b0, 1'b0, -1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midfill_busy: got %b required 1", busy); end
        #2; rst_n = 1'b0; #1;
        checks++; if ({sram_csb, sram_wsb} !== 2'b11) begin failures++; $display("FAIL midrst_strobes: got %b required 11", {sram_csb, sram_wsb}); end
        checks++; if ({in_ready, busy} !== 2'b00) begin failures++; $display("FAIL midrst_ready_busy: got %b required 00", {in_ready, busy}); end
        checks++; if (rows_written !== 7'd0) begin failures++; $display("FAIL midrst_rows: got %0d required 0", rows_written); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if (wr_addr_q.size() !== b) begin failures++; $display("FAIL midrst_no_write: writes %0d required %0d", wr_addr_q.size(), b); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle: in_ready %b required 0", in_ready); end
    endtask

    task automatic test_single_row();
        int b, d_at;
        logic [511:0] d;
        b = wr_addr_q.size();
        do_start(6'd5);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL start_ready: got %b required 1", in_ready); end
        send(32, 16'h0000, 1'b1, 1'b0, -1);
        wait_done(10, d_at);
        checks++; if (wr_addr_q.size() !== b + 1) begin failures++; $display("FAIL single_count: writes %0d required %0d", wr_addr_q.size() - b, 1); end
        if (wr_addr_q.size() > b) begin
            d = wr_data_q[b];
            checks++; if (wr_addr_q[b] !== 6'd5) begin failures++; $display("FAIL single_addr: got %0d required 5", wr_addr_q[b]); end
            checks++; if (d[511:496] !== 16'h0000) begin failures++; $display("FAIL single_top: got %h required 0000", d[511:496]); end
            checks++; if (d[15:0] !== 16'h001F) begin failures++; $display("FAIL single_bottom: got %h required 001f", d[15:0]); end
            checks++; if (d !== row_of(16'h0000, 32)) begin failures++; $display("FAIL single_row: got %h required %h", d, row_of(16'h0000, 32)); end
        end
        checks++; if (d_at !== last_wr_cyc + 1) begin failures++; $display("FAIL single_done_time: done at %0d required %0d", d_at, last_wr_cyc + 1); end
        checks++; if (rows_written !== 7'd1) begin failures++; $display("FAIL single_rows: got %0d required 1", rows_written); end
        @(posedge clk); #1;
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL single_done_pulse: done/busy %b required 00", {done, busy}); end
    endtask

    task automatic test_back_to_back();
        int b, s0, d_at;
        b = wr_addr_q.size();
        s0 = stall_cnt;
        do_start(6'd0);
        send(96, 16'h0000, 1'b1, 1'b0, -1);
        wait_done(10, d_at);
        checks++; if (wr_addr_q.size() !== b + 3) begin failures++; $display("FAIL b2b_count: writes %0d required 3", wr_addr_q.size() - b); end
        if (wr_addr_q.size() >= b + 3) begin
            for (int r = 0; r < 3; r++) begin
                checks++; if (wr_addr_q[b + r] !== 6'(r)) begin failures++; $display("FAIL b2b_addr%0d: got %0d required %0d", r, wr_addr_q[b + r], r); end
                checks++; if (wr_data_q[b + r] !== row_of(16'(32 * r), 32)) begin failures++; $display("FAIL b2b_data%0d: got %h required %h", r, wr_data_q[b + r], row_of(16'(32 * r), 32)); end
            end
        end
        checks++; if (stall_cnt - s0 !== 3) begin failures++; $display("FAIL b2b_stalls: in_ready low %0d cycles required 3", stall_cnt - s0); end
        checks++; if (d_at - start_cyc !== 99) begin failures++; $display("FAIL b2b_latency: done after %0d cycles required 99", d_at - start_cyc); end
        checks++; if (rows_written !== 7'd3) begin failures++; $display("FAIL b2b_rows: got %0d required 3", rows_written); end
        checks++; if (wrap_err !== 1'b0) begin failures++; $display("FAIL b2b_wrap: got %b required 0", wrap_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int b, d_at;
        b = wr_addr_q.size();
        do_start(6'd63);
        send(64, 16'h4000, 1'b1, 1'b0, -1);
        wait_done(10, d_at);
        checks++; if (wr_addr_q.size() !== b + 2) begin failures++; $display("FAIL wrap_count: writes %0d required 2", wr_addr_q.size() - b); end
        if (wr_addr_q.size() >= b + 2) begin
            checks++; if (wr_addr_q[b] !== 6'd63) begin failures++; $display("FAIL wrap_addr0: got %0d required 63", wr_addr_q[b]); end
            checks++; if (wr_addr_q[b + 1] !== 6'd0) begin failures++; $display("FAIL wrap_addr1: got %0d required 0", wr_addr_q[b + 1]); end
            checks++; if (wr_data_q[b + 1] !== row_of(16'h4020, 32)) begin failures++; $display("FAIL wrap_data1: got %h required %h", wr_data_q[b + 1], row_of(16'h4020, 32)); end
        end
        checks++; if (wrap_err !== 1'b1) begin failures++; $display("FAIL wrap_err: got %b required 1", wrap_err); end
        checks++; if (rows_written !== 7'd2) begin failures++; $display("FAIL wrap_rows: got %0d required 2", rows_written); end
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        int b, dc, d_at;
        b = wr_addr_q.size();
        dc = done_cnt;
        do_start(6'd20);
        checks++; if (wrap_err !== 1'b0) begin failures++; $display("FAIL partial_wrap_clear: got %b required 0", wrap_err); end
        send(10, 16'h0B00, 1'b1, 1'b0, -1);
        wait_done(10, d_at);
        @(posedge clk); #1;
        checks++; if (done_cnt - dc !== 1) begin failures++; $display("FAIL partial_done_cnt: got %0d required 1", done_cnt - dc); end
`ifdef WPACK_FLUSH_EN
        checks++; if (wr_addr_q.size() !== b + 1) begin failures++; $display("FAIL partial_count: writes %0d required 1", wr_addr_q.size() - b); end
        if (wr_addr_q.size() > b) begin
            checks++; if (wr_addr_q[b] !== 6'd20) begin failures++; $display("FAIL partial_addr: got %0d required 20", wr_addr_q[b]); end
            checks++; if (wr_data_q[b] !== row_of(16'h0B00, 10)) begin failures++; $display("FAIL partial_data: got %h required %h", wr_data_q[b], row_of(16'h0B00, 10)); end
        end
        checks++; if (rows_written !== 7'd1) begin failures++; $display("FAIL partial_rows: got %0d required 1", rows_written); end
`else
        checks++; if (wr_addr_q.size() !== b) begin failures++; $display("FAIL partial_count: writes %0d required 0", wr_addr_q.size() - b); end
        checks++; if (rows_written !== 7'd0) begin failures++; $display("FAIL partial_rows: got %0d required 0", rows_written); end
`endif
    endtask

    task automatic test_backpressure();
        int b, d_at;
        b = wr_addr_q.size();
        do_start(6'd8);
        send(32, 16'hA000, 1'b1, 1'b1, 12);
        wait_done(10, d_at);
        checks++; if (wr_addr_q.size() !== b + 1) begin failures++; $display("FAIL bp_count: writes %0d required 1", wr_addr_q.size() - b); end
        if (wr_addr_q.size() > b) begin
            checks++; if (wr_addr_q[b] !== 6'd8) begin failures++; $display("FAIL bp_addr: got %0d required 8", wr_addr_q[b]); end
            checks++; if (wr_data_q[b] !== row_of(16'hA000, 32)) begin failures++; $display("FAIL bp_data: got %h required %h", wr_data_q[b], row_of(16'hA000, 32)); end
        end
        checks++; if (rows_written !== 7'd1) begin failures++; $display("FAIL bp_rows: got %0d required 1", rows_written); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: busy %b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_wrap();
        test_partial();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
